program_counter: RTL
====================

# program_counter

Parametrised program-counter unit for the CPU fetch stage; the registered successor to the fixed-step incrementer. It holds the current fetch address and advances it each enabled cycle by a configurable step. It also supports absolute load, signed relative branch and stall. An optional return-address stack adds call and return.

## Interface
Parameters:
- SIZE, 16, address width in bits
- AMOUNT, 1, sequential step added per advance (unsigned, < 2^SIZE)
- RESET_ADDR, 0, value loaded into pc on reset
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2; used only with PC_RETURN_STACK_EN)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance enable; 0 = stall, pc holds
- load  in  1  absolute jump request
- load_addr  in  SIZE  jump/call target
- branch  in  1  relative branch request
- offset  in  SIZE  two's-complement branch offset, relative to current pc
- call  in  1  push pc+AMOUNT, jump to load_addr (macro only)
- ret  in  1  pop return address into pc (macro only)
- pc  out  SIZE  current fetch address (registered)
- pc_next  out  SIZE  combinational value pc will take at next edge
- wrap  out  1  registered one-cycle pulse: last sequential advance wrapped past 2^SIZE-1
- stack_ovf  out  1  sticky: call issued while stack full (macro only)
- stack_unf  out  1  sticky: ret issued while stack empty (macro only)

## Operation
- Operation select per cycle, fixed priority: !en → HOLD; call → CALL; ret → RET; load → LOAD; branch → BRANCH; else INC.
- HOLD: pc, stack, wrap unchanged except wrap deasserts.
- INC: pc ← (pc + AMOUNT) mod 2^SIZE; wrap ← carry out of the add.
- BRANCH: pc ← (pc + offset) mod 2^SIZE; offset sign-extended implicitly by modular add; wrap ← 0.
- LOAD: pc ← load_addr; wrap ← 0.
- CALL: push (pc + AMOUNT) mod 2^SIZE; pc ← load_addr. When full: push overwrites oldest entry (circular), depth stays STACK_DEPTH, stack_ovf ← 1.
- RET: when non-empty: pc ← top entry, pop. When empty: behaves as INC, stack_ovf unchanged, stack_unf ← 1.
- Stack state: write pointer plus count 0..STACK_DEPTH; empty = count 0; full = count STACK_DEPTH.
- Sticky flags clear only on rst.
- Request inputs are ignored (no side effects) when a higher-priority request wins the same cycle.

## Timing
- Reset values: pc = RESET_ADDR, wrap = 0, stack count = 0, stack_ovf = 0, stack_unf = 0; pc_next reflects the reset value plus the current inputs.
- Reset asserted mid-operation clears everything immediately, regardless of clk or pending requests.
- All requests are sampled at the rising edge; the new pc is visible one cycle later (latency 1).
- pc_next equals the value pc takes at the next edge; it has no register stage.
- wrap is high for exactly the cycle following the wrapping INC.

## Configuration
- PC_RETURN_STACK_EN defined: call/ret, return stack, stack_ovf/stack_unf present and behave as above.
- Undefined: call and ret ports absent (or tied off and ignored); stack_ovf and stack_unf are constant 0. Priority reduces to HOLD, LOAD, BRANCH, INC; no stack storage is synthesised.

## Structure
- Shared package pc_pkg holds:
  - the pc_op_t enum: PC_HOLD, PC_INC, PC_BRANCH, PC_LOAD, PC_CALL, PC_RET
  - the priority-decode function returning pc_op_t
- One sub-module, return_stack: circular LIFO with push, pop, top, full, empty, parameterised by SIZE and STACK_DEPTH. It is instantiated only under PC_RETURN_STACK_EN.

## Test plan
- Reset and increment: rst=1 with RESET_ADDR=16'h0100, release, en=1 for 3 cycles → pc reaches 0x0101, 0x0102, 0x0103; wrap stays 0.
- Wrap-around: SIZE=8, AMOUNT=3, pc=0xFE, INC → pc=0x01; wrap=1 for one cycle only. Stall with en=0 → pc holds 0x01.
- Branch/load priority: pc=0x0040, branch with offset=16'hFFF0 → pc=0x0030. Next cycle load=1 (0x1234) with branch=1 → pc=0x1234.
- Call/ret: pc=0x0010, call to 0x0200 → pc=0x0200, stack holds 0x0011. After 2 INCs, ret → pc=0x0011, stack empty.
- Stack overflow/underflow: STACK_DEPTH=4, 5 calls → stack_ovf=1 and 4 returns yield the last 4 pushes. A 5th ret → INC behaviour, stack_unf=1.
- Async reset mid-call: rst asserted between edges while call=1 → pc=RESET_ADDR immediately; stack empty; flags 0.

Source files
------------

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and the priority decoder for the program counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_INC    = 3'd1,
        PC_BRANCH = 3'd2,
        PC_LOAD   = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_op_t;

    // Fixed priority: stall wins, then call, ret, load, branch, else increment.
    function automatic pc_op_t pc_decode(
        input logic en,
        input logic call,
        input logic ret,
        input logic load,
        input logic branch
    );
        pc_op_t op;
        if (!en)         op = PC_HOLD;
        else if (call)   op = PC_CALL;
        else if (ret)    op = PC_RET;
        else if (load)   op = PC_LOAD;
        else if (branch) op = PC_BRANCH;
        else             op = PC_INC;
        return op;
    endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_stack
// Description : Circular LIFO of return addresses. A push while full overwrites
//               the oldest entry; a pop while empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module return_stack
    import pc_pkg::*;
#(
    parameter int unsigned SIZE        = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [SIZE-1:0] push_data,
    output logic [SIZE-1:0] top,
    output logic            full,
    output logic            empty
);

    localparam int unsigned       PTR_W   = $clog2(STACK_DEPTH);
    localparam int unsigned       CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(STACK_DEPTH);

    logic [SIZE-1:0]  mem_q [STACK_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q, count_d;

    // wr_ptr points at the next free slot; when full that slot is the oldest
    // entry, so wrapping the pointer overwrites it naturally.
    assign rd_ptr = wr_ptr_q - PTR_W'(1);
    assign top    = mem_q[rd_ptr];
    assign full   = (count_q == C_DEPTH);
    assign empty  = (count_q == '0);

    // Pointer and occupancy update; count saturates at depth on overwrite.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr_d = rd_ptr;
            count_d  = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers; reset empties the stack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : return_stack
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Fetch-stage program counter with step increment, absolute load,
//               relative branch and stall. Define PC_RETURN_STACK_EN to add
//               call/ret through a circular return-address stack; without it
//               call/ret are ignored and the stack flags read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned     SIZE        = 16,
    parameter int unsigned     AMOUNT      = 1,
    parameter logic [SIZE-1:0] RESET_ADDR  = '0,
    parameter int unsigned     STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [SIZE-1:0] load_addr,
    input  logic            branch,
    input  logic [SIZE-1:0] offset,
    input  logic            call,
    input  logic            ret,
    output logic [SIZE-1:0] pc,
    output logic [SIZE-1:0] pc_next,
    output logic            wrap,
    output logic            stack_ovf,
    output logic            stack_unf
);

    localparam logic [SIZE-1:0] C_STEP = SIZE'(AMOUNT);

    pc_op_t          op;
    logic [SIZE-1:0] pc_q, pc_d;
    logic            wrap_q, wrap_d;
    logic [SIZE:0]   inc_sum;
    logic            call_en, ret_en;
    logic            stk_push, stk_pop, stk_full, stk_empty;
    logic [SIZE-1:0] stk_top;
    logic            set_ovf, set_unf;

    assign inc_sum = {1'b0, pc_q} + {1'b0, C_STEP};
    assign op      = pc_decode(en, call_en, ret_en, load, branch);

    // Next pc, wrap pulse and stack side effects for the selected operation.
    always_comb begin
        pc_d     = pc_q;
        wrap_d   = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        case (op)
            PC_HOLD: begin
                pc_d = pc_q;
            end
            PC_INC: begin
                pc_d   = inc_sum[SIZE-1:0];
                wrap_d = inc_sum[SIZE];
            end
            PC_BRANCH: begin
                // Modular add makes the offset behave as two's complement.
                pc_d = pc_q + offset;
            end
            PC_LOAD: begin
                pc_d = load_addr;
            end
            PC_CALL: begin
                pc_d     = load_addr;
                stk_push = 1'b1;
                set_ovf  = stk_full;
            end
            PC_RET: begin
                if (!stk_empty) begin
                    pc_d    = stk_top;
                    stk_pop = 1'b1;
                end else begin
                    // Return with nothing stacked falls back to a plain step.
                    pc_d    = inc_sum[SIZE-1:0];
                    wrap_d  = inc_sum[SIZE];
                    set_unf = 1'b1;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Program counter and wrap pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_ADDR;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;
    assign wrap    = wrap_q;

`ifdef PC_RETURN_STACK_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    assign call_en = call;
    assign ret_en  = ret;
    assign ovf_d   = ovf_q | set_ovf;
    assign unf_d   = unf_q | set_unf;

    return_stack #(
        .SIZE        (SIZE),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (inc_sum[SIZE-1:0]),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Sticky stack error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
`else
    logic unused_ok;

    assign call_en   = 1'b0;
    assign ret_en    = 1'b0;
    assign stk_full  = 1'b0;
    assign stk_empty = 1'b1;
    assign stk_top   = '0;
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
    assign unused_ok = &{1'b0, call, ret, stk_push, stk_pop, set_ovf, set_unf,
                         (STACK_DEPTH != 0)};
`endif

endmodule : program_counter
`default_nettype wire
